// File: rtl/pic_rd_sched.sv
// ============================================================================
// Module  : pic_rd_sched
// Brief   : Picture-RAM B-port read scheduler. The display path has strict
//           priority; frame bursts for the shift loader fill the idle slots.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pic_rd_sched #(
    parameter int ADDR_WIDTH = 17,
    parameter int DATA_WIDTH = 24,
    parameter int PIC_WORDS  = 129600,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk_100M,
    input  logic                  rst_n,
    input  logic                  pic_done,
    input  logic                  frame_start,
    input  logic                  disp_req,
    input  logic [ADDR_WIDTH-1:0] disp_addr,
    output logic [DATA_WIDTH-1:0] disp_data,
    output logic                  disp_vld,
    input  logic                  shift_rdy,
    output logic [DATA_WIDTH-1:0] shift_data,
    output logic [ADDR_WIDTH-1:0] shift_addr,
    output logic                  shift_vld,
    output logic                  shift_busy,
    output logic                  shift_done,
    output logic                  ram_enb,
    output logic [ADDR_WIDTH-1:0] ram_addrb,
    input  logic [DATA_WIDTH-1:0] ram_doutb
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(PIC_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                r_state;
    logic                  r_frame_start;
    logic [ADDR_WIDTH-1:0] r_rd_cnt;

    logic [RD_LATENCY:1]   r_tag_vld;
    logic [RD_LATENCY:1]   r_tag_shift;
    logic [ADDR_WIDTH-1:0] r_tag_addr [1:RD_LATENCY];

    logic w_start;
    logic w_abort;
    logic w_disp_gnt;
    logic w_shift_gnt;
    logic w_ret_disp;
    logic w_ret_shift;
    logic w_last_ret;

    assign w_start = frame_start & ~r_frame_start;
    assign w_abort = w_start & (r_state != IDLE);

    // Grants are gated by rst_n so the RAM port stays quiet while in reset.
    // No shift read is issued in a restart cycle: its tag would be stale anyway.
    assign w_disp_gnt  = rst_n & disp_req;
    assign w_shift_gnt = rst_n & ~disp_req & shift_rdy & ~w_start & (r_state == BURST);

    assign ram_enb   = w_disp_gnt | w_shift_gnt;
    assign ram_addrb = w_disp_gnt  ? disp_addr :
                       w_shift_gnt ? r_rd_cnt  : '0;

    assign w_ret_disp  = r_tag_vld[RD_LATENCY] & ~r_tag_shift[RD_LATENCY];
    assign w_ret_shift = r_tag_vld[RD_LATENCY] &  r_tag_shift[RD_LATENCY] & ~w_abort;
    assign w_last_ret  = w_ret_shift & (r_state == DRAIN) &
                         (r_tag_addr[RD_LATENCY] == LAST_ADDR);

    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_frame_start <= 1'b0;
            r_rd_cnt      <= '0;
            shift_busy    <= 1'b0;
        end else begin
            r_frame_start <= frame_start;
            // Busy covers the done-pulse cycle, where the state is already IDLE.
            shift_busy    <= (r_state != IDLE) | (w_start & pic_done);
            case (r_state)
                IDLE: begin
                    if (w_start && pic_done) begin
                        r_state  <= BURST;
                        r_rd_cnt <= '0;
                    end
                end
                BURST: begin
                    if (w_start) begin
                        r_rd_cnt <= '0;
                    end else if (w_shift_gnt) begin
                        if (r_rd_cnt == LAST_ADDR) begin
                            r_state <= DRAIN;
                        end else begin
                            r_rd_cnt <= r_rd_cnt + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (w_start) begin
                        r_state  <= BURST;
                        r_rd_cnt <= '0;
                    end else if (w_last_ret) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            r_tag_vld   <= '0;
            r_tag_shift <= '0;
            for (int k = 1; k <= RD_LATENCY; k++) begin
                r_tag_addr[k] <= '0;
            end
            disp_data   <= '0;
            disp_vld    <= 1'b0;
            shift_data  <= '0;
            shift_addr  <= '0;
            shift_vld   <= 1'b0;
            shift_done  <= 1'b0;
        end else begin
            r_tag_vld[1]   <= w_disp_gnt | w_shift_gnt;
            r_tag_shift[1] <= w_shift_gnt;
            r_tag_addr[1]  <= r_rd_cnt;
            // A restart kills every shift tag still in flight; display tags survive.
            for (int k = 2; k <= RD_LATENCY; k++) begin
                r_tag_vld[k]   <= r_tag_vld[k-1] & ~(w_abort & r_tag_shift[k-1]);
                r_tag_shift[k] <= r_tag_shift[k-1];
                r_tag_addr[k]  <= r_tag_addr[k-1];
            end

            disp_vld <= w_ret_disp;
            if (w_ret_disp) begin
                disp_data <= ram_doutb;
            end

            shift_vld <= w_ret_shift;
            if (w_ret_shift) begin
                shift_data <= ram_doutb;
                shift_addr <= r_tag_addr[RD_LATENCY];
            end
            shift_done <= w_last_ret;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pic_rd_sched.sv
// ============================================================================
// Module  : tb_pic_rd_sched
// Brief   : Randomized self-checking bench for pic_rd_sched with a scoreboard
//           model of display returns and frame-burst sequencing.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pic_rd_sched;

    localparam int AW = 17;
    localparam int DW = 24;
    localparam int PW = 300;
    localparam int L  = 2;

    logic          clk_100M = 1'b0;
    logic          rst_n;
    logic          pic_done;
    logic          frame_start;
    logic          disp_req;
    logic [AW-1:0] disp_addr;
    logic [DW-1:0] disp_data;
    logic          disp_vld;
    logic          shift_rdy;
    logic [DW-1:0] shift_data;
    logic [AW-1:0] shift_addr;
    logic          shift_vld;
    logic          shift_busy;
    logic          shift_done;
    logic          ram_enb;
    logic [AW-1:0] ram_addrb;
    logic [DW-1:0] ram_doutb;

    always #5 clk_100M = ~clk_100M;

    pic_rd_sched #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .PIC_WORDS (PW),
        .RD_LATENCY(L)
    ) dut (
        .clk_100M   (clk_100M),
        .rst_n      (rst_n),
        .pic_done   (pic_done),
        .frame_start(frame_start),
        .disp_req   (disp_req),
        .disp_addr  (disp_addr),
        .disp_data  (disp_data),
        .disp_vld   (disp_vld),
        .shift_rdy  (shift_rdy),
        .shift_data (shift_data),
        .shift_addr (shift_addr),
        .shift_vld  (shift_vld),
        .shift_busy (shift_busy),
        .shift_done (shift_done),
        .ram_enb    (ram_enb),
        .ram_addrb  (ram_addrb),
        .ram_doutb  (ram_doutb)
    );

    function automatic logic [DW-1:0] pix(input logic [AW-1:0] a);
        return ({7'd0, a} * 24'd40503) ^ 24'h5A5A5A;
    endfunction

    // Picture RAM: fixed L-cycle read pipeline
    logic [DW-1:0] rpipe [1:L];
    always @(posedge clk_100M) begin
        if (ram_enb) rpipe[1] <= pix(ram_addrb);
        for (int k = 2; k <= L; k++) rpipe[k] <= rpipe[k-1];
    end
    assign ram_doutb = rpipe[L];

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    always @(posedge clk_100M) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model state
    typedef struct {
        int            due;
        logic [DW-1:0] d;
    } dexp_t;
    dexp_t dq[$];
    bit mon_on    = 0;
    bit act       = 0;
    bit fs_prev   = 0;
    int exp_next  = PW;
    int iss_next  = 0;
    int edge_cyc  = 0;
    int done_cyc  = 0;
    int n_done    = 0;
    int n_dvld    = 0;

    always @(negedge clk_100M) begin
        if (mon_on) begin
            if (dq.size() > 0 && dq[0].due == cyc) begin
                check("disp_vld", disp_vld, 1);
                check("disp_data", disp_data, dq[0].d);
                void'(dq.pop_front());
            end else begin
                check("disp_vld_idle", disp_vld, 0);
            end
            if (disp_vld) n_dvld++;

            if (disp_req) begin
                check("gnt_disp_en", ram_enb, 1);
                check("gnt_disp_addr", ram_addrb, disp_addr);
                dq.push_back('{due: cyc + L + 1, d: pix(disp_addr)});
            end else if (ram_enb) begin
                check("iss_addr", ram_addrb, iss_next);
                check("iss_in_burst", act, 1);
                check("iss_rdy", shift_rdy, 1);
                iss_next++;
            end else begin
                check("no_gnt_addr", ram_addrb, 0);
            end
            if (!disp_req && !act) check("idle_no_enb", ram_enb, 0);

            check("busy", shift_busy, act);
            check("done", shift_done, shift_vld && exp_next == PW - 1);
            if (shift_vld) begin
                check("shift_addr", shift_addr, exp_next);
                check("shift_data", shift_data, pix(AW'(exp_next)));
                exp_next++;
            end
            if (shift_done) begin
                act = 0;
                n_done++;
                done_cyc = cyc;
            end
            if (frame_start && !fs_prev && (pic_done || act)) begin
                act      = 1;
                exp_next = 0;
                iss_next = 0;
                edge_cyc = cyc;
            end
            fs_prev = frame_start;
        end
    end

    task automatic tick();
        @(posedge clk_100M);
        #1;
    endtask

    task automatic rand_inputs();
        pic_done    = 1'($urandom);
        frame_start = 1'($urandom);
        disp_req    = 1'($urandom);
        disp_addr   = AW'($urandom);
        shift_rdy   = 1'($urandom);
    endtask

    task automatic start_burst();
        frame_start = 1'b0;
        tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    // mode 0: steady, 1: shift_rdy toggles, 2: random display traffic and backpressure
    task automatic wait_done(input int budget, input int mode);
        int n0;
        int i;
        n0 = n_done;
        i  = 0;
        while (n_done == n0 && i < budget) begin
            if (mode == 1) shift_rdy = ~shift_rdy;
            if (mode == 2) begin
                disp_req  = ($urandom_range(0, 99) < 30);
                disp_addr = AW'($urandom);
                shift_rdy = ($urandom_range(0, 99) < 70);
            end
            tick();
            i++;
        end
        disp_req  = 1'b0;
        shift_rdy = 1'b1;
        if (n_done == n0) check("done_timeout", 0, 1);
    endtask

    initial begin
        int n0;
        int lat;
        int i;
        rst_n = 1'b0;
        rand_inputs();

        repeat (6) begin
            tick();
            rand_inputs();
            @(negedge clk_100M);
            check("rst_disp", {disp_vld, disp_data}, 0);
            check("rst_shift", {shift_vld, shift_data, shift_addr, shift_busy, shift_done}, 0);
            check("rst_ram", {ram_enb, ram_addrb}, 0);
        end

        tick();
        pic_done = 0; frame_start = 0; disp_req = 0; disp_addr = '0; shift_rdy = 0;
        rst_n  = 1'b1;
        mon_on = 1;
        repeat (3) tick();

        // Start edge with picture not ready is ignored
        pic_done    = 1'b0;
        shift_rdy   = 1'b1;
        frame_start = 1'b1;
        repeat (20) tick();
        frame_start = 1'b0;
        tick();
        check("ign_busy", shift_busy, 0);
        check("ign_ndone", n_done, 0);

        // Clean burst, exact latency
        pic_done = 1'b1;
        start_burst();
        wait_done(PW + 50, 0);
        lat = done_cyc - edge_cyc;
        check("clean_lat", lat, PW + L + 1);
        tick();
        tick();
        check("clean_busy_fall", shift_busy, 0);

        // Display priority in the middle of a burst
        start_burst();
        repeat (PW / 2) tick();
        n_dvld = 0;
        for (int k = 0; k < 10; k++) begin
            disp_req  = 1'b1;
            disp_addr = AW'(500 + k);
            tick();
        end
        disp_req = 1'b0;
        wait_done(PW + 50, 0);
        check("prio_disp_cnt", n_dvld, 10);
        check("prio_lat", done_cyc - edge_cyc, PW + L + 1 + 10);

        // Backpressure: shift_rdy toggles every cycle
        start_burst();
        wait_done(3 * PW, 1);
        lat = done_cyc - edge_cyc;
        check("bp_lat_lo", lat >= 2 * PW - 2, 1);
        check("bp_lat_hi", lat <= 2 * PW + L + 4, 1);

        // Restart mid-burst: only the restarted burst may complete
        n0 = n_done;
        start_burst();
        i = 0;
        while (iss_next < PW / 2 && i < PW) begin
            tick();
            i++;
        end
        check("rs_reach", iss_next >= PW / 2, 1);
        start_burst();
        wait_done(PW + 50, 0);
        repeat (L + 4) tick();
        check("rs_single_done", n_done, n0 + 1);

        // Random display traffic and backpressure
        repeat (3) begin
            start_burst();
            wait_done(8 * PW, 2);
            repeat (5) tick();
        end
        check("busy_end", shift_busy, 0);
        check("dq_empty", dq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

`default_nettype wire
